swt16_mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between instruction fetch (read-only) and the MEM stage (read/write).

---
 rtl/swt16_mem_arbiter_pkg.sv | 14 +
 rtl/swt16_arb2.sv | 41 ++++
 rtl/swt16_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_swt16_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swt16_mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
// FSM state encoding and port-owner encoding.
package swt16_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/swt16_arb2.sv
// Two-way alternating arbiter: req[0]=IF, req[1]=DM.
// Ports: clock, reset, req, update (commit grant), grant (owner).
module swt16_arb2
  import swt16_mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant = OWN_IF;
    unique case (1'b1)
      (req == 2'b11): grant = ~last_q;
      (req == 2'b10): grant = OWN_DM;
      default:        grant = OWN_IF;
    endcase
  end

  // Only a real conflict moves the alternation pointer.
  always_comb begin
    last_d = last_q;
    if (update && (req == 2'b11)) begin
      last_d = grant;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= OWN_IF;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/swt16_mem_arbiter.sv
// Shares one req/ack memory between fetch (read) and MEM (rd/wr).
// Ports: if_* fetch side, dm_* data side, mem_* memory side, stalls.
module swt16_mem_arbiter
  import swt16_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int WORD_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [WORD_WIDTH-1:0] if_rdata,
  output logic                  if_rvalid,
  output logic                  if_stall,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [WORD_WIDTH-1:0] dm_wdata,
  output logic [WORD_WIDTH-1:0] dm_rdata,
  output logic                  dm_rvalid,
  output logic                  dm_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  mem_err
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WORD_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  mem_err_q, mem_err_d;
  logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
  logic                  grant;
  logic                  grant_en;

  swt16_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    ({dm_req, if_req}),
    .update (grant_en),
    .grant  (grant)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_err_d   = mem_err_q;
    to_cnt_d    = to_cnt_q;
    grant_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          grant_en  = 1'b1;
          owner_d   = grant;
          mem_req_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = ST_BUSY;
          if (grant == OWN_DM) begin
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
          end
        end
      end
      ST_BUSY: begin
        // An ack on the limit cycle still wins over the timeout.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
          if (!mem_we_q) begin
            if (owner_q == OWN_DM) begin
              dm_rdata_d = mem_rdata;
            end else begin
              if_rdata_d = mem_rdata;
            end
          end
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          mem_err_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end else if (TO_EN) begin
          to_cnt_d = to_cnt_q + TO_WIDTH'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_err_q   <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_err_q   <= mem_err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign if_rvalid = (state_q == ST_RESP) && (owner_q == OWN_IF);
  assign dm_rvalid = (state_q == ST_RESP) && (owner_q == OWN_DM);
  assign if_stall  = if_req && !if_rvalid;
  assign dm_stall  = dm_req && !dm_rvalid;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_swt16_mem_arbiter.sv
// Bench for swt16_mem_arbiter: schedule-based model, memory responder.
// Directed scenarios plus a randomized latency mix.
module tb_swt16_mem_arbiter;

  localparam int AW = 12;
  localparam int WW = 16;
  localparam int TO = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [WW-1:0] wdata;
    int            lat;
  } item_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [WW-1:0] if_rdata;
  logic          if_rvalid;
  logic          if_stall;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [WW-1:0] dm_wdata = '0;
  logic [WW-1:0] dm_rdata;
  logic          dm_rvalid;
  logic          dm_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic [WW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          mem_err;

  swt16_mem_arbiter #(
    .ADDR_WIDTH     (AW),
    .WORD_WIDTH     (WW),
    .TIMEOUT_CYCLES (TO),
    .TO_WIDTH       (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_rvalid (if_rvalid),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_rvalid (dm_rvalid),
    .dm_stall  (dm_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_err   (mem_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clock) cyc++;

  item_t if_q[$];
  item_t dm_q[$];
  item_t cur_if;
  item_t cur_dm;
  bit    if_act = 0;
  bit    dm_act = 0;
  bit    seen_if_rv = 0;
  bit    seen_dm_rv = 0;

  logic [WW-1:0] mem_arr [0:4095];
  int  cur_lat = 1;
  int  rsp_n = 0;
  bit  force_ack = 0;

  // model: one access = grant cycle g, busy g+1..g+k, resp g+k+1
  int            m_lo = -10, m_hi = -10, m_rv = -10, m_free = 0;
  int            m_k, g_lat;
  bit            m_own, m_last, m_we, m_to, m_err;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_wdata, m_exp, m_if_rd, m_dm_rd;
  bit            e_mreq, e_ifv, e_dmv;

  int n_if_rv = 0, n_dm_rv = 0, n_if_st = 0, n_dm_st = 0;
  int n_mreq = 0, n_wbusy = 0, if_rv_cyc = 0;
  int dut_order[$];

  bit            p_if_st = 0, p_dm_st = 0;
  logic [AW-1:0] p_if_addr, p_dm_addr;
  logic          p_dm_we;
  logic [WW-1:0] p_dm_wdata;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h",
               nm, cyc, act, exp);
    end
  endtask

  // memory responder: ack in the lat-th cycle of mem_req
  always @(negedge clock) begin
    if (mem_req) begin
      rsp_n++;
      if (rsp_n == cur_lat) begin
        mem_ack = 1'b1;
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        else mem_rdata = mem_arr[mem_addr];
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'hDEAD ^ 16'(rsp_n);
      end
    end else begin
      rsp_n = 0;
      mem_ack = force_ack;
      mem_rdata = 16'hD00D;
    end
  end

  // model + per-cycle compare
  always @(negedge clock) begin
    if (reset) begin
      m_lo = -10; m_hi = -10; m_rv = -10;
      m_free = cyc + 1;
      m_last = 0; m_err = 0;
      m_if_rd = '0; m_dm_rd = '0;
      seen_if_rv = 0; seen_dm_rv = 0;
      p_if_st = 0; p_dm_st = 0;
    end else begin
      if (cyc == m_rv) begin
        if (m_to) m_err = 1;
        else if (!m_we) begin
          if (m_own) m_dm_rd = m_exp;
          else m_if_rd = m_exp;
        end
      end
      if (cyc >= m_free && (if_req || dm_req)) begin
        if (if_req && dm_req) begin
          m_own = !m_last;
          m_last = m_own;
        end else begin
          m_own = dm_req;
        end
        m_we    = m_own ? dm_we : 1'b0;
        m_addr  = m_own ? dm_addr : if_addr;
        m_wdata = dm_wdata;
        g_lat   = m_own ? cur_dm.lat : cur_if.lat;
        m_to    = (g_lat == 0) || (g_lat > TO);
        m_k     = m_to ? TO : g_lat;
        m_lo    = cyc + 1;
        m_hi    = cyc + m_k;
        m_rv    = cyc + m_k + 1;
        m_free  = cyc + m_k + 2;
        m_exp   = mem_arr[m_addr];
        cur_lat = g_lat;
      end
      e_mreq = (cyc >= m_lo) && (cyc <= m_hi);
      e_ifv  = (cyc == m_rv) && !m_own;
      e_dmv  = (cyc == m_rv) && m_own;
      chk("if_stall", if_stall, if_req && !e_ifv);
      chk("dm_stall", dm_stall, dm_req && !e_dmv);
      chk("if_rvalid", if_rvalid, e_ifv);
      chk("dm_rvalid", dm_rvalid, e_dmv);
      chk("mem_req", mem_req, e_mreq);
      chk("mem_err", mem_err, m_err);
      chk("if_rdata", if_rdata, m_if_rd);
      chk("dm_rdata", dm_rdata, m_dm_rd);
      if (e_mreq) begin
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (p_if_st && if_req)
        assert (if_addr == p_if_addr)
          else $error("if port changed addr while stalled");
      if (p_dm_st && dm_req)
        assert (dm_addr == p_dm_addr && dm_we == p_dm_we &&
                dm_wdata == p_dm_wdata)
          else $error("dm port changed request while stalled");
      p_if_st = if_stall; p_if_addr = if_addr;
      p_dm_st = dm_stall; p_dm_addr = dm_addr;
      p_dm_we = dm_we; p_dm_wdata = dm_wdata;
      n_if_st += int'(if_stall);
      n_dm_st += int'(dm_stall);
      n_mreq  += int'(mem_req);
      n_wbusy += int'(mem_req && mem_we && mem_wdata == 16'h0A5A);
      if (if_rvalid) begin
        n_if_rv++; if_rv_cyc = cyc; dut_order.push_back(0);
      end
      if (dm_rvalid) begin
        n_dm_rv++; dut_order.push_back(1);
      end
      seen_if_rv = if_rvalid;
      seen_dm_rv = dm_rvalid;
    end
  end

  task automatic drive();
    if (if_act && seen_if_rv) if_act = 0;
    if (dm_act && seen_dm_rv) dm_act = 0;
    if (!if_act && if_q.size() > 0) begin
      cur_if = if_q.pop_front(); if_act = 1;
    end
    if (!dm_act && dm_q.size() > 0) begin
      cur_dm = dm_q.pop_front(); dm_act = 1;
    end
    if_req   = if_act;
    if_addr  = cur_if.addr;
    dm_req   = dm_act;
    dm_we    = cur_dm.we;
    dm_addr  = cur_dm.addr;
    dm_wdata = cur_dm.wdata;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    drive();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((if_act || dm_act || if_q.size() > 0 || dm_q.size() > 0)
           && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL wait_idle cyc=%0d budget=%0d expired", cyc, budget);
    end
    step();
  endtask

  int ord[4] = '{1, 0, 1, 0};
  int t1_cyc;
  int base_if, base_dm;

  initial begin
    for (int i = 0; i < 4096; i++) mem_arr[i] = 16'(i * 7 + 3);
    mem_arr[12'h010] = 16'hBEEF;
    mem_arr[12'h030] = 16'h1234;
    mem_arr[12'h100] = 16'h7777;
    cur_if = '{we: 1'b0, addr: '0, wdata: '0, lat: 1};
    cur_dm = '{we: 1'b0, addr: '0, wdata: '0, lat: 1};

    @(negedge clock);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rvalid", dm_rvalid, 0);
    step();
    reset = 1'b0;
    step();

    // 1: IF read, ack in first busy cycle
    n_if_st = 0; n_if_rv = 0;
    if_q.push_back('{we: 1'b0, addr: 12'h010, wdata: '0, lat: 1});
    step();
    t1_cyc = cyc;
    wait_idle(20);
    chk("t1_if_rdata", if_rdata, 16'hBEEF);
    chk("t1_stall_cycles", n_if_st, 2);
    chk("t1_rvalid_pulses", n_if_rv, 1);
    chk("t1_rvalid_at", if_rv_cyc - t1_cyc, 2);

    // 2: DM write, ack after 3 busy cycles
    n_dm_st = 0; n_dm_rv = 0; n_wbusy = 0;
    dm_q.push_back('{we: 1'b1, addr: 12'h100, wdata: 16'h0A5A, lat: 3});
    wait_idle(20);
    chk("t2_wbusy_cycles", n_wbusy, 3);
    chk("t2_dm_stall", n_dm_st, 4);
    chk("t2_rvalid_pulses", n_dm_rv, 1);
    chk("t2_dm_rdata", dm_rdata, 0);
    chk("t2_mem_word", mem_arr[12'h100], 16'h0A5A);

    // 3: conflicting streams alternate, DM first
    dut_order.delete();
    if_q.push_back('{we: 1'b0, addr: 12'h020, wdata: '0, lat: 1});
    if_q.push_back('{we: 1'b0, addr: 12'h030, wdata: '0, lat: 1});
    dm_q.push_back('{we: 1'b0, addr: 12'h100, wdata: '0, lat: 1});
    dm_q.push_back('{we: 1'b0, addr: 12'h010, wdata: '0, lat: 1});
    wait_idle(40);
    chk("t3_grants", dut_order.size(), 4);
    if (dut_order.size() == 4)
      for (int i = 0; i < 4; i++) chk("t3_order", dut_order[i], ord[i]);
    chk("t3_if_rdata", if_rdata, 16'h1234);
    chk("t3_dm_rdata", dm_rdata, 16'hBEEF);

    // 4: timeout, then a normal access
    n_mreq = 0; n_if_rv = 0;
    if_q.push_back('{we: 1'b0, addr: 12'h020, wdata: '0, lat: 0});
    wait_idle(30);
    chk("t4_busy_cycles", n_mreq, 4);
    chk("t4_mem_err", mem_err, 1);
    chk("t4_if_rvalid", n_if_rv, 1);
    chk("t4_if_rdata", if_rdata, 16'h1234);
    dm_q.push_back('{we: 1'b0, addr: 12'h100, wdata: '0, lat: 2});
    wait_idle(30);
    chk("t4_next_rdata", dm_rdata, 16'h0A5A);
    chk("t4_err_sticky", mem_err, 1);

    // 5: reset in the second busy cycle, stray ack afterwards
    if_q.push_back('{we: 1'b0, addr: 12'h040, wdata: '0, lat: 0});
    step();
    step();
    step();
    reset = 1'b1;
    if_q.delete(); if_act = 0; if_req = 1'b0;
    @(negedge clock);
    chk("t5_in_busy", mem_req, 1);
    step();
    reset = 1'b0;
    force_ack = 1;
    @(negedge clock);
    chk("t5_mem_req", mem_req, 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_mem_err", mem_err, 0);
    chk("t5_if_rdata", if_rdata, 0);
    chk("t5_dm_rdata", dm_rdata, 0);
    chk("t5_if_rvalid", if_rvalid, 0);
    step();
    force_ack = 0;
    @(negedge clock);
    chk("t5_ack_ignored", mem_req, 0);
    chk("t5_no_rvalid", if_rvalid | dm_rvalid, 0);

    // 6: mixed latency 1..8, both ports busy
    base_if = n_if_rv; base_dm = n_dm_rv;
    for (int i = 0; i < 10; i++) begin
      if_q.push_back('{we: 1'b0, addr: 12'($urandom_range(0, 255)),
                       wdata: '0, lat: $urandom_range(1, 8)});
      dm_q.push_back('{we: 1'($urandom_range(0, 1)),
                       addr: 12'($urandom_range(0, 255)),
                       wdata: 16'($urandom),
                       lat: $urandom_range(1, 8)});
    end
    wait_idle(400);
    chk("t6_if_done", n_if_rv - base_if, 10);
    chk("t6_dm_done", n_dm_rv - base_dm, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
